// File: rtl/serial_pkg.sv
// Shared constants for the serial-to-parallel receive front end:
// FSM state encoding and default alignment parameters.
package serial_pkg;

  // FSM state encoding
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  // Alignment / idle symbol and number of aligned COMs needed for lock
  localparam logic [7:0] COM_DEF     = 8'hBC;
  localparam logic [3:0] BC_LOCK_DEF = 4'd4;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel front end. Shifts in a 1-bit MSB-first stream on dclk,
// hunts for the COM symbol with a sliding window, confirms byte alignment
// with BC_LOCK consecutive boundary-aligned COMs, then emits one byte every
// 8 dclk cycles.
//
// Output semantics: valid_out is a pure qualifier with no back-pressure.
// data_out and valid_out change only on byte-boundary edges and are held for
// 8 cycles; valid_out = 1 means data_out carries a payload byte, valid_out = 0
// means idle (COM) or not yet locked. The consumer samples once per byte.
module serial_paralelo
  import serial_pkg::*;
#(
  parameter logic [7:0] COM     = COM_DEF,
  parameter logic [3:0] BC_LOCK = BC_LOCK_DEF  // legal range 1..15
) (
  input  logic       dclk,
  input  logic       reset_L,
  input  logic       data_serial,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  logic [1:0] state_q,   state_d;
  logic [7:0] sr_q,      sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q,  bc_cnt_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;

  logic [7:0] next_byte;
  logic       is_com;
  logic       boundary;
  logic [3:0] bc_inc;

  // The byte completed by the bit arriving this cycle
  assign next_byte = {sr_q[6:0], data_serial};
  assign is_com    = (next_byte == COM);
  assign boundary  = (bit_cnt_q == 3'd7);
  assign bc_inc    = (bc_cnt_q == 4'hF) ? bc_cnt_q : bc_cnt_q + 4'd1;

  // Next-state logic: shift register, counters, alignment FSM, output byte
  always_comb begin
    sr_d      = next_byte;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;

    case (state_q)
      SEARCH: begin
        // Sliding window: any bit position may start a byte
        if (is_com) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = (BC_LOCK == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_LOCK) state_d = ACTIVE;
          end else begin
            // Alignment broken; resume the sliding search next cycle
            bc_cnt_d = 4'd0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Sticky until reset; COM bytes pass through as idle
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = next_byte;
          valid_d = !is_com;
        end
      end
      default: begin
        state_d   = SEARCH;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge dclk) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo. Each byte sent pushes the expected
// {active, valid_out, data_out} for its LSB edge; that edge pops it and every
// other edge checks that the previous value is still held.
module tb_serial_paralelo;

  logic       dclk;
  logic       reset_L;
  logic       data_serial;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  logic [9:0] exp_q[$];
  logic [9:0] cur_exp;
  int         cmp_cnt;
  int         fail_cnt;

  serial_paralelo dut (
    .dclk        (dclk),
    .reset_L     (reset_L),
    .data_serial (data_serial),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active)
  );

  // Clock generation
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string tag);
    logic [9:0] got;
    got = {active, valid_out, data_out};
    cmp_cnt++;
    assert (got === cur_exp) else begin
      fail_cnt++;
      $error("FAIL %s: got act/vld/data=%b/%b/%h expected %b/%b/%h",
             tag, got[9], got[8], got[7:0], cur_exp[9], cur_exp[8], cur_exp[7:0]);
    end
  endtask

  // Drive one bit on the falling edge, check just after the rising edge
  task automatic send_bit(input logic b, input bit boundary, input string tag);
    @(negedge dclk);
    reset_L     = 1'b1;
    data_serial = b;
    @(posedge dclk);
    #1;
    if (boundary) cur_exp = exp_q.pop_front();
    check(tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_act,
                           input logic exp_vld, input logic [7:0] exp_data,
                           input string tag);
    exp_q.push_back({exp_act, exp_vld, exp_data});
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0), tag);
  endtask

  task automatic reset_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge dclk);
      reset_L     = 1'b0;
      data_serial = 1'b1;
      @(posedge dclk);
      #1;
      cur_exp = 10'h000;
      check(tag);
    end
  endtask

  initial begin
    logic [7:0] partial;
    cmp_cnt     = 0;
    fail_cnt    = 0;
    cur_exp     = 10'h000;
    reset_L     = 1'b0;
    data_serial = 1'b0;

    // Basic lock
    reset_cycles(2, "reset");
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, "pre_zero");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "com1");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "com2");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "com3");
    send_byte(8'hBC, 1'b1, 1'b0, 8'h00, "com4_lock");
    send_byte(8'hAA, 1'b1, 1'b1, 8'hAA, "byte_aa");
    send_byte(8'h55, 1'b1, 1'b1, 8'h55, "byte_55");

    // Idle in ACTIVE
    send_byte(8'h12, 1'b1, 1'b1, 8'h12, "byte_12");
    send_byte(8'hBC, 1'b1, 1'b0, 8'hBC, "idle_bc");
    send_byte(8'h34, 1'b1, 1'b1, 8'h34, "byte_34");

    // Reset in the middle of a payload byte
    partial = 8'h9A;
    for (int i = 7; i >= 4; i--) send_bit(partial[i], 1'b0, "mid_hold");
    reset_cycles(1, "mid_reset");

    // Broken alignment, then relock with 4 fresh COMs
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "brk_com1");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "brk_com2");
    send_byte(8'h00, 1'b0, 1'b0, 8'h00, "brk_zero");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "re_com1");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "re_com2");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "re_com3");
    send_byte(8'hBC, 1'b1, 1'b0, 8'h00, "re_com4_lock");
    send_byte(8'h77, 1'b1, 1'b1, 8'h77, "byte_77");

    // Mis-phased stream after a fresh reset
    reset_cycles(1, "phase_reset");
    for (int i = 0; i < 5; i++)
      send_bit(logic'($urandom_range(0, 1)), 1'b0, "rand_prefix");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "ph_com1");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "ph_com2");
    send_byte(8'hBC, 1'b0, 1'b0, 8'h00, "ph_com3");
    send_byte(8'hBC, 1'b1, 1'b0, 8'h00, "ph_com4_lock");
    send_byte(8'hBC, 1'b1, 1'b0, 8'hBC, "ph_com5");
    send_byte(8'hBC, 1'b1, 1'b0, 8'hBC, "ph_com6");
    send_byte(8'hF0, 1'b1, 1'b1, 8'hF0, "byte_f0");
    send_byte(8'h01, 1'b1, 1'b1, 8'h01, "byte_01");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Serial-to-parallel front end of the receive path, directly upstream of `demuxL2`. It samples a 1-bit serial stream on the bit clock `dclk` and aligns to byte boundaries using the COM symbol 0xBC. Once aligned, it presents one byte plus a valid flag every 8 `dclk` cycles on the `data_in`/`valid` pair that `demuxL2` consumes on `cclk`. `dclk` is 8× `cclk`. Top-level clock generation phase-aligns each `cclk` rising edge to the middle of the 8-cycle byte hold window.

## Interface
- `COM`, 8'hBC, alignment/idle symbol.
- `BC_LOCK`, 4, consecutive byte-aligned COM symbols required to reach ACTIVE; legal range 1..15.

- `dclk`  in  1  bit clock, rising-edge; the only clock.
- `reset_L`  in  1  reset, synchronous, active-low; sampled on the `dclk` rising edge.
- `data_serial`  in  1  serial data, MSB first.
- `data_out`  out  8  assembled byte; connects to `demuxL2.data_in`.
- `valid_out`  out  1  `data_out` holds a payload byte; connects to `demuxL2.valid`.
- `active`  out  1  byte lock achieved.

## Operation
- **Datapath**
  - 8-bit shift register: `sr <= {sr[6:0], data_serial}` every cycle.
  - `next_byte = {sr[6:0], data_serial}`.
  - `bit_cnt`: 3 bits, wraps 7→0.
  - `bc_cnt`: 4 bits, saturating.
- **States**
  - SEARCH, ALIGN, ACTIVE. State is encoded in the package.
  - SEARCH: evaluate `next_byte` every cycle (sliding window). If `next_byte == COM`, then `bit_cnt <= 0`, `bc_cnt <= 1`, and go to ALIGN (or directly to ACTIVE if `BC_LOCK == 1`).
  - ALIGN: `bit_cnt` increments. At the byte boundary (`bit_cnt == 7`):
    - `next_byte == COM`: `bc_cnt++`. On reaching `BC_LOCK`, go to ACTIVE.
    - Otherwise: `bc_cnt <= 0` and go to SEARCH. The sliding search resumes on the next cycle.
  - ACTIVE: at each byte boundary, `data_out <= next_byte` and `valid_out <= (next_byte != COM)`. The state is sticky until reset; there is no lock-loss detection.
- **Outputs outside ACTIVE**: `data_out` holds 0 and `valid_out` holds 0. `active` is high only in ACTIVE.
- **Reset values**: `data_out = 8'h00`, `valid_out = 0`, `active = 0`, state = SEARCH, `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`.

## Timing
- Every output is registered and changes only at byte-boundary edges, so each value is held for exactly 8 `dclk` cycles.
- **Latency**: the edge that samples a byte's LSB also updates `data_out`. The value is visible one clock-to-q later.
- **Lock edge**: `active` rises on the edge that samples the LSB of the `BC_LOCK`-th COM. The first ACTIVE byte boundary is 8 cycles later, so the COM that achieves lock is never output.
- **Reset mid-stream**: takes effect at the next `dclk` edge and overrides everything. Full realignment is then required: at least `8*BC_LOCK` cycles of COM.
- **False COM in payload while in SEARCH/ALIGN**: it can start ALIGN. The next non-COM at a boundary returns the block to SEARCH.
- **Payload bytes equal to COM in ACTIVE**: treated as idle (`valid_out = 0`). The protocol forbids 0xBC as payload.
- **Simultaneous events at a boundary**: reset has highest priority, then the state-transition decision.

## Structure
- Package `serial_pkg` holds:
  - the state encoding: SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2;
  - the default `COM` (8'hBC) and `BC_LOCK` (4).
- One module, no sub-modules. The shift register, counters and FSM are small enough to keep flat.
- The module is also synthesized to a gate-level version against `cmos_cells.v`. It is checked in the existing test bench alongside the behavioral model.

## Test plan
- **Basic lock**: reset low for 2 cycles, then 3 bits of 0, then 4×0xBC, then 0xAA, 0x55.
  - `active` rises at the LSB edge of the 4th 0xBC.
  - Output 0xAA with `valid_out = 1` for 8 cycles, then 0x55 with `valid_out = 1`.
- **Idle in ACTIVE**: after lock, send 0x12, 0xBC, 0x34.
  - `valid_out` follows 1, 0, 1.
  - `data_out` follows 0x12, 0xBC, 0x34.
- **Broken alignment**: send 0xBC, 0xBC, 0x00, then 4×0xBC, then 0x77.
  - `active` stays low through the 0x00.
  - `active` locks on the 4th COM after it; 0x77 is output.
- **Mis-phased stream**: prefix 5 random bits before 6×0xBC, then 0xF0.
  - Lock occurs on the correct boundary; 0xF0 is output exactly.
- **Reset mid-operation**: assert `reset_L = 0` during a payload byte.
  - All outputs go to 0 on the next edge; state returns to SEARCH.
  - Relock requires 4 new COM bytes.
- **Chain check**: drive `demuxL2` from this block.
  - 0x01..0x04 alternate between `data_out0` and `data_out1` per `demuxL2` rules.
  - Behavioral and structural outputs match cycle-for-cycle.
